// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-slot front end for the vending datapath.
// Grants one coin per cycle round-robin across NSLOT acceptors and
// accumulates credit. Once credit reaches PRICE it runs a dispense
// handshake, then pays the remainder back one 5rs coin per chg_ack.
// If an ack does not arrive within TIMEOUT cycles the block latches
// FAULT, which only reset clears.
// Optional feature: define REFUND_EN to add the cancel input. A cancel
// in COLLECT with nonzero credit refunds the whole credit through the
// change handshake.
module vend_sequencer #(
  parameter int NSLOT   = 2,
  parameter int PRICE   = 15,
  parameter int CW      = 6,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSLOT-1:0]   coin_valid,
  input  logic [2*NSLOT-1:0] coin_code,
  output logic [NSLOT-1:0]   coin_grant,
  output logic               disp_req,
  input  logic               disp_ack,
  output logic               chg_req,
  input  logic               chg_ack,
  output logic [CW-1:0]      credit,
  output logic               busy,
  output logic               fault
`ifdef REFUND_EN
  ,
  input  logic               cancel
`endif
);

  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] FIVE_C  = CW'(5);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            disp_req_q, disp_req_d;
  logic            chg_req_q, chg_req_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;

  logic            found;
  logic [NSLOT-1:0] sel_oh;
  logic [1:0]      sel_code;
  logic [PW-1:0]   sel_idx;
  logic [CW-1:0]   coin_val;
  logic [CW-1:0]   sum;
  logic [CW-1:0]   left;
  logic            refund;
  logic            take_coin;

  // Round-robin pick: the lowest valid slot overall is the fallback, and the
  // lowest valid slot at or above rr_q overrides it. This is the same as
  // searching from rr_q with wrap-around.
  always_comb begin
    found    = 1'b0;
    sel_oh   = '0;
    sel_code = 2'b00;
    sel_idx  = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (coin_valid[i]) begin
        found     = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_code  = coin_code[2*i +: 2];
        sel_idx   = PW'(i);
      end
    end
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (coin_valid[i] && (i >= int'(rr_q))) begin
        found     = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_code  = coin_code[2*i +: 2];
        sel_idx   = PW'(i);
      end
    end
  end

  // Coin value of the selected slot. Invalid codes are still flushed but add nothing.
  always_comb begin
    case (sel_code)
      2'b01:   coin_val = CW'(5);
      2'b10:   coin_val = CW'(10);
      default: coin_val = '0;
    endcase
  end

`ifdef REFUND_EN
  assign refund = (state_q == ST_COLLECT) && cancel && (credit_q != '0);
`else
  assign refund = 1'b0;
`endif

  assign take_coin  = (state_q == ST_COLLECT) && found && !refund;
  // Grants are combinational. They are forced low while reset is held.
  assign coin_grant = (take_coin && reset) ? sel_oh : '0;
  assign sum        = credit_q + coin_val;

  // Next-state and registered-output computation for the sequencer FSM
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    disp_req_d = disp_req_q;
    chg_req_d  = chg_req_q;
    busy_d     = busy_q;
    fault_d    = fault_q;
    left       = credit_q - PRICE_C;
    case (state_q)
      ST_COLLECT: begin
        timer_d = '0;
        if (refund) begin
          state_d   = ST_CHANGE;
          chg_req_d = 1'b1;
          busy_d    = 1'b1;
        end else if (take_coin) begin
          credit_d = sum;
          rr_d     = (sel_idx == PW'(NSLOT - 1)) ? '0 : sel_idx + PW'(1);
          if (sum >= PRICE_C) begin
            state_d    = ST_DISPENSE;
            disp_req_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          disp_req_d = 1'b0;
          timer_d    = '0;
          credit_d   = left;
          if (left != '0) begin
            state_d   = ST_CHANGE;
            chg_req_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
            busy_d  = 1'b0;
          end
        end else if (timer_q == TLAST) begin
          state_d    = ST_FAULT;
          disp_req_d = 1'b0;
          busy_d     = 1'b0;
          fault_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CHANGE: begin
        if (chg_ack) begin
          timer_d  = '0;
          credit_d = credit_q - FIVE_C;
          if (credit_q == FIVE_C) begin
            state_d   = ST_COLLECT;
            chg_req_d = 1'b0;
            busy_d    = 1'b0;
          end
        end else if (timer_q == TLAST) begin
          state_d   = ST_FAULT;
          chg_req_d = 1'b0;
          busy_d    = 1'b0;
          fault_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_FAULT: begin
        // Parked until reset. Credit stays frozen for diagnosis.
        disp_req_d = 1'b0;
        chg_req_d  = 1'b0;
        busy_d     = 1'b0;
        fault_d    = 1'b1;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // State and registered-output flops. Async reset drops any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_COLLECT;
      credit_q   <= '0;
      rr_q       <= '0;
      timer_q    <= '0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      disp_req_q <= disp_req_d;
      chg_req_q  <= chg_req_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign disp_req = disp_req_q;
  assign chg_req  = chg_req_q;
  assign credit   = credit_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus a randomized run.
// Every cycle is checked against a transaction-level model of credit,
// outstanding dispense, owed change and the ack wait counter.
module tb_vend_sequencer;

  localparam int NSLOT   = 2;
  localparam int PRICE   = 15;
  localparam int CW      = 6;
  localparam int TIMEOUT = 255;

  logic               clk;
  logic               reset;
  logic [NSLOT-1:0]   coin_valid;
  logic [2*NSLOT-1:0] coin_code;
  logic [NSLOT-1:0]   coin_grant;
  logic               disp_req, disp_ack, chg_req, chg_ack;
  logic [CW-1:0]      credit;
  logic               busy, fault;
  logic               cancel;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: credit held, dispense outstanding, change owed,
  // latched fault, round-robin start slot, and cycles spent waiting for an ack
  int m_credit, m_rr, m_wait;
  bit m_disp, m_chg, m_fault;

  vend_sequencer #(.NSLOT(NSLOT), .PRICE(PRICE), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_grant(coin_grant),
    .disp_req(disp_req), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_ack(chg_ack),
    .credit(credit), .busy(busy), .fault(fault)
`ifdef REFUND_EN
    , .cancel(cancel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_rr = 0; m_wait = 0;
    m_disp = 0; m_chg = 0; m_fault = 0;
  endtask

  task automatic set_coin(input int s, input logic [1:0] c);
    coin_valid = coin_valid | (NSLOT'(1) << s);
    coin_code  = (coin_code & ~((2*NSLOT)'(3) << (2*s))) | ((2*NSLOT)'(c) << (2*s));
  endtask

  // Advance one clock. Grants are checked at the falling edge, and the
  // registered outputs are checked just after the rising edge.
  task automatic cycle();
    int g, idx, val;
    bit coll, can;
    logic [NSLOT-1:0] eg;
    logic [1:0] c;
    coll = !m_disp && !m_chg && !m_fault;
    can  = 1'b0;
`ifdef REFUND_EN
    can = coll && cancel && (m_credit > 0);
`endif
    g  = -1;
    eg = '0;
    if (coll && !can) begin
      for (int k = 0; k < NSLOT; k++) begin
        idx = (m_rr + k) % NSLOT;
        if (g < 0 && ((coin_valid >> idx) & NSLOT'(1)) != '0) g = idx;
      end
    end
    if (g >= 0) eg = NSLOT'(1) << g;
    @(negedge clk);
    chk("grant", 32'(coin_grant), 32'(eg));
    if (m_fault) begin
    end else if (m_disp) begin
      if (disp_ack) begin
        m_credit -= PRICE; m_disp = 0; m_wait = 0;
        m_chg = (m_credit > 0);
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin m_fault = 1; m_disp = 0; end
      end
    end else if (m_chg) begin
      if (chg_ack) begin
        m_credit -= 5; m_wait = 0;
        if (m_credit == 0) m_chg = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin m_fault = 1; m_chg = 0; end
      end
    end else if (can) begin
      m_chg = 1; m_wait = 0;
    end else if (g >= 0) begin
      c   = 2'(coin_code >> (2*g));
      val = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
      m_credit += val;
      m_rr = (g + 1) % NSLOT;
      if (m_credit >= PRICE) begin m_disp = 1; m_wait = 0; end
    end
    @(posedge clk);
    #1;
    if (g >= 0) coin_valid = coin_valid & ~(NSLOT'(1) << g);
    chk("credit",   32'(credit),   32'(m_credit));
    chk("disp_req", 32'(disp_req), 32'(m_disp));
    chk("chg_req",  32'(chg_req),  32'(m_chg));
    chk("busy",     32'(busy),     32'(m_disp | m_chg));
    chk("fault",    32'(fault),    32'(m_fault));
  endtask

  task automatic do_reset();
    coin_valid = '0; disp_ack = 0; chg_ack = 0; cancel = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rc;
    int r;
    reset = 1'b0; coin_valid = '1; coin_code = '0;
    disp_ack = 0; chg_ack = 0; cancel = 0;
    model_reset();
    #3;
    chk("rst_credit", 32'(credit),     32'd0);
    chk("rst_disp",   32'(disp_req),   32'd0);
    chk("rst_chg",    32'(chg_req),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_fault",  32'(fault),      32'd0);
    chk("rst_grant",  32'(coin_grant), 32'd0);
    do_reset();

    // Slot 0 inserts 5rs then 10rs for an exact sale with no change.
    set_coin(0, 2'b01); cycle();
    chk("t1_credit5", 32'(credit), 32'd5);
    set_coin(0, 2'b10); cycle();
    chk("t1_credit15", 32'(credit), 32'd15);
    chk("t1_disp", 32'(disp_req), 32'd1);
    disp_ack = 1; cycle(); disp_ack = 0;
    chk("t1_after_ack", 32'(credit), 32'd0);
    chk("t1_no_chg", 32'(chg_req), 32'd0);

    // Slot 1 inserts 10rs twice, so the sale leaves 5rs of change.
    set_coin(1, 2'b10); cycle();
    set_coin(1, 2'b10); cycle();
    chk("t2_credit20", 32'(credit), 32'd20);
    disp_ack = 1; cycle(); disp_ack = 0;
    chk("t2_credit5", 32'(credit), 32'd5);
    chk("t2_chg", 32'(chg_req), 32'd1);
    chg_ack = 1; cycle(); chg_ack = 0;
    chk("t2_credit0", 32'(credit), 32'd0);
    chk("t2_chg_off", 32'(chg_req), 32'd0);

    // Both slots present a coin together and are served in round-robin order.
    set_coin(0, 2'b10); set_coin(1, 2'b10);
    #1 chk("t3_first", 32'(coin_grant), 32'd1);
    cycle();
    #1 chk("t3_second", 32'(coin_grant), 32'd2);
    cycle();
    disp_ack = 1; cycle(); disp_ack = 0;
    chg_ack = 1; cycle(); chg_ack = 0;
    set_coin(0, 2'b01); set_coin(1, 2'b01);
    #1 chk("t3_rr_end", 32'(coin_grant), 32'd1);
    cycle(); cycle();

    // Dispense never acknowledged, so the block times out into FAULT.
    do_reset();
    set_coin(0, 2'b10); cycle();
    set_coin(0, 2'b01); cycle();
    repeat (TIMEOUT - 1) cycle();
    chk("t4_pre_fault", 32'(fault), 32'd0);
    chk("t4_pre_disp",  32'(disp_req), 32'd1);
    cycle();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_disp_off", 32'(disp_req), 32'd0);
    set_coin(1, 2'b10);
    #1 chk("t4_no_grant", 32'(coin_grant), 32'd0);
    disp_ack = 1; cycle(); disp_ack = 0;
    chk("t4_frozen", 32'(credit), 32'd15);
    chk("t4_stuck", 32'(fault), 32'd1);

    // Reset asserted in the middle of the change handshake.
    do_reset();
    set_coin(0, 2'b10); cycle();
    set_coin(1, 2'b10); cycle();
    disp_ack = 1; cycle(); disp_ack = 0;
    chk("t5_in_chg", 32'(chg_req), 32'd1);
    #1 reset = 1'b0; chg_ack = 1;
    #1;
    chk("t5_credit", 32'(credit), 32'd0);
    chk("t5_chg", 32'(chg_req), 32'd0);
    chk("t5_fault", 32'(fault), 32'd0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    cycle();
    chk("t5_stale_ack", 32'(credit), 32'd0);
    chg_ack = 0;

`ifdef REFUND_EN
    // Insert 10rs, then cancel and take the refund as two 5rs coins.
    do_reset();
    set_coin(0, 2'b10); cycle();
    cancel = 1; set_coin(1, 2'b01);
    #1 chk("t6_no_grant", 32'(coin_grant), 32'd0);
    cycle(); cancel = 0;
    chk("t6_chg", 32'(chg_req), 32'd1);
    chg_ack = 1; cycle();
    chk("t6_credit5", 32'(credit), 32'd5);
    cycle(); chg_ack = 0;
    chk("t6_credit0", 32'(credit), 32'd0);
`endif

    // Random run: coins stay presented until granted, acks arrive at random.
    do_reset();
    repeat (3000) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (((coin_valid >> s) & NSLOT'(1)) == '0 && $urandom_range(3) == 0) begin
          r  = int'($urandom_range(7));
          rc = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
          set_coin(s, rc);
        end
      end
      disp_ack = ($urandom_range(2) == 0);
      chg_ack  = ($urandom_range(2) == 0);
`ifdef REFUND_EN
      cancel   = ($urandom_range(15) == 0);
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
